program_counter: RTL and testbench

Fetch-side program counter and branch-target unit for the 8-bit core. It sits directly downstream of the ALU. Each cycle it consumes the ALU's `taken` flag together with the decoder's branch, jump and halt controls, and produces the next instruction address for instruction memory. Branch and jump targets are not encoded in the instruction. They are held in an internal target lookup table (LUT), loaded before a run and indexed by a 5-bit field of the instruction.

---
 rtl/program_counter.sv | 162 ++++++++++++++++
 tb/tb_program_counter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// -----------------------------------------------------------------------------
// program_counter
//
// Fetch-side program counter and branch-target unit for the 8-bit core. Each
// cycle it takes the ALU taken flag and the decoder branch/jump/halt controls
// and produces the next instruction address. Branch and jump targets come from
// an internal target LUT. The LUT is loaded while the core is not running and
// is indexed by a 5-bit instruction field.
//
// Optional feature macro: PC_OVERRUN_CHECK_EN
//   defined   : a +1 advance from the last address stops the run (DONE) and
//               raises Overrun instead of wrapping.
//   undefined : the PC wraps to 0 and Overrun is tied low.
//
// Ports
//   Clk        in   clock, all state updates on the rising edge
//   Reset      in   synchronous active-high reset, clears state, PC and LUT
//   Start      in   begin a run from address 0 (accepted in IDLE/DONE)
//   Halt       in   halt instruction at the current PC
//   BranchEn   in   conditional branch at the current PC
//   Taken      in   ALU branch-condition result (used only with BranchEn)
//   Jump       in   unconditional jump at the current PC
//   TargIdx    in   target LUT read index
//   LutWe      in   target LUT write enable (ignored in RUN)
//   LutWaddr   in   target LUT write index
//   LutWdata   in   target LUT write data (absolute address)
//   ProgCtr    out  registered instruction address
//   Running    out  high in RUN
//   Done       out  high in DONE
//   Overrun    out  PC ran past the last address (feature macro only)
// -----------------------------------------------------------------------------
module program_counter #(
  parameter int PC_W      = 10,
  parameter int LUT_DEPTH = 32,
  localparam int IDX_W    = $clog2(LUT_DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Halt,
  input  logic             BranchEn,
  input  logic             Taken,
  input  logic             Jump,
  input  logic [IDX_W-1:0] TargIdx,
  input  logic             LutWe,
  input  logic [IDX_W-1:0] LutWaddr,
  input  logic [PC_W-1:0]  LutWdata,
  output logic [PC_W-1:0]  ProgCtr,
  output logic             Running,
  output logic             Done,
  output logic             Overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] lut_q [LUT_DEPTH];
  logic [PC_W-1:0] lut_target;
  logic            redirect;
  logic            lut_wr;

`ifdef PC_OVERRUN_CHECK_EN
  logic            overrun_q, overrun_d;
`endif

  // Combinational read from the registered table; a write lands at the edge
  // and is therefore visible to reads from the following cycle.
  assign lut_target = lut_q[TargIdx];
  assign redirect   = Jump || (BranchEn && Taken);
  assign lut_wr     = LutWe && (state_q != ST_RUN);

  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
`ifdef PC_OVERRUN_CHECK_EN
    overrun_d = overrun_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (Start) begin
          state_d = ST_RUN;
          pc_d    = '0;
`ifdef PC_OVERRUN_CHECK_EN
          overrun_d = 1'b0;
`endif
        end
      end
      ST_RUN: begin
        // Halt outranks any redirect; PC holds at the halt address.
        if (Halt) begin
          state_d = ST_DONE;
        end else if (redirect) begin
          pc_d = lut_target;
        end else begin
`ifdef PC_OVERRUN_CHECK_EN
          // Stepping past the last address ends the run instead of wrapping.
          if (&pc_q) begin
            state_d   = ST_DONE;
            overrun_d = 1'b1;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
`else
          pc_d = pc_q + PC_W'(1);
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
`ifdef PC_OVERRUN_CHECK_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
`ifdef PC_OVERRUN_CHECK_EN
      overrun_q <= overrun_d;
`endif
    end
  end

  // NOTE: the target table is deliberately reset (all entries to 0), so it is
  // built from flops rather than a RAM macro; a reset mid-run must leave no
  // stale targets behind.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < LUT_DEPTH; i++) begin
        lut_q[i] <= '0;
      end
    end else if (lut_wr) begin
      lut_q[LutWaddr] <= LutWdata;
    end
  end

  assign ProgCtr = pc_q;
  assign Running = (state_q == ST_RUN);
  assign Done    = (state_q == ST_DONE);
`ifdef PC_OVERRUN_CHECK_EN
  assign Overrun = overrun_q;
`else
  assign Overrun = 1'b0;
`endif

endmodule

// File: tb/tb_program_counter.sv
// -----------------------------------------------------------------------------
// tb_program_counter
//
// Directed testbench for program_counter with the default parameters
// (PC_W=10, LUT_DEPTH=32). Expected values are hand-computed. Inputs are
// driven 1 ns after a rising edge. Outputs are sampled at that same point,
// which is after the registers have settled.
// Follows PC_OVERRUN_CHECK_EN the same way the design does.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_program_counter;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic       Halt;
  logic       BranchEn;
  logic       Taken;
  logic       Jump;
  logic [4:0] TargIdx;
  logic       LutWe;
  logic [4:0] LutWaddr;
  logic [9:0] LutWdata;
  logic [9:0] ProgCtr;
  logic       Running;
  logic       Done;
  logic       Overrun;

  int n_tests;
  int n_failed;

  program_counter #(
    .PC_W      (10),
    .LUT_DEPTH (32)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Halt     (Halt),
    .BranchEn (BranchEn),
    .Taken    (Taken),
    .Jump     (Jump),
    .TargIdx  (TargIdx),
    .LutWe    (LutWe),
    .LutWaddr (LutWaddr),
    .LutWdata (LutWdata),
    .ProgCtr  (ProgCtr),
    .Running  (Running),
    .Done     (Done),
    .Overrun  (Overrun)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_ctl();
    Start    = 1'b0;
    Halt     = 1'b0;
    BranchEn = 1'b0;
    Taken    = 1'b0;
    Jump     = 1'b0;
    TargIdx  = '0;
    LutWe    = 1'b0;
  endtask

  task automatic lut_write(input logic [4:0] a, input logic [9:0] d);
    LutWe    = 1'b1;
    LutWaddr = a;
    LutWdata = d;
    step();
    LutWe    = 1'b0;
  endtask

  initial begin
    n_tests  = 0;
    n_failed = 0;
    LutWaddr = '0;
    LutWdata = '0;
    idle_ctl();

    // Reset state
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
    check("rst_pc",      32'(ProgCtr), 32'h0);
    check("rst_running", 32'(Running), 32'h0);
    check("rst_done",    32'(Done),    32'h0);
    check("rst_overrun", 32'(Overrun), 32'h0);
    step();
    check("idle_hold_pc",  32'(ProgCtr), 32'h0);
    check("idle_hold_run", 32'(Running), 32'h0);

    // Start then free-running count 0..5
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("start_pc",  32'(ProgCtr), 32'h0);
    check("start_run", 32'(Running), 32'h1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("count_pc",  32'(ProgCtr), 32'(i));
      check("count_run", 32'(Running), 32'h1);
    end

    // Branch taken / not taken with LUT[3]=0x120
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    lut_write(5'd3, 10'h120);
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    step();
    check("br_setup_pc", 32'(ProgCtr), 32'h2);
    BranchEn = 1'b1;
    Taken    = 1'b1;
    TargIdx  = 5'd3;
    step();
    idle_ctl();
    check("br_taken_pc", 32'(ProgCtr), 32'h120);

    Halt = 1'b1;
    step();
    Halt = 1'b0;
    check("halt1_done", 32'(Done),    32'h1);
    check("halt1_run",  32'(Running), 32'h0);
    check("halt1_pc",   32'(ProgCtr), 32'h120);
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("restart_pc",   32'(ProgCtr), 32'h0);
    check("restart_done", 32'(Done),    32'h0);
    step();
    step();
    BranchEn = 1'b1;
    Taken    = 1'b0;
    TargIdx  = 5'd3;
    step();
    idle_ctl();
    check("br_not_taken_pc", 32'(ProgCtr), 32'h3);
    Taken   = 1'b1;
    TargIdx = 5'd3;
    step();
    idle_ctl();
    check("taken_no_br_pc", 32'(ProgCtr), 32'h4);

    // Halt beats Jump and taken branch at PC=7
    step();
    step();
    step();
    check("pc7", 32'(ProgCtr), 32'h7);
    Halt     = 1'b1;
    Jump     = 1'b1;
    BranchEn = 1'b1;
    Taken    = 1'b1;
    TargIdx  = 5'd3;
    step();
    check("prio_done", 32'(Done),    32'h1);
    check("prio_pc",   32'(ProgCtr), 32'h7);
    step();
    check("done_ignore_ctl_pc",   32'(ProgCtr), 32'h7);
    check("done_ignore_ctl_done", 32'(Done),    32'h1);
    idle_ctl();
    Start = 1'b1;
    step();
    check("prio_restart_pc",   32'(ProgCtr), 32'h0);
    check("prio_restart_done", 32'(Done),    32'h0);
    // Start held while already running is ignored
    step();
    Start = 1'b0;
    check("start_in_run_pc", 32'(ProgCtr), 32'h1);

    // LUT write in RUN is ignored
    Halt = 1'b1;
    step();
    Halt = 1'b0;
    lut_write(5'd1, 10'h040);
    lut_write(5'd5, 10'h053);
    Start = 1'b1;
    step();
    Start = 1'b0;
    lut_write(5'd1, 10'h3FF);
    check("run_wr_pc", 32'(ProgCtr), 32'h1);
    Jump    = 1'b1;
    TargIdx = 5'd1;
    step();
    idle_ctl();
    check("run_wr_ignored_pc", 32'(ProgCtr), 32'h040);

    // Reset mid-run at 0x055
    Jump    = 1'b1;
    TargIdx = 5'd5;
    step();
    idle_ctl();
    step();
    step();
    check("pre_reset_pc", 32'(ProgCtr), 32'h055);
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_pc",   32'(ProgCtr), 32'h0);
    check("midrst_run",  32'(Running), 32'h0);
    check("midrst_done", 32'(Done),    32'h0);
    step();
    step();
    check("midrst_hold_pc", 32'(ProgCtr), 32'h0);
    Start = 1'b1;
    step();
    Start = 1'b0;
    Jump    = 1'b1;
    TargIdx = 5'd1;
    step();
    check("lut1_cleared_pc", 32'(ProgCtr), 32'h0);
    TargIdx = 5'd5;
    step();
    idle_ctl();
    check("lut5_cleared_pc", 32'(ProgCtr), 32'h0);

    // Reset and Start together: Reset wins
    Reset = 1'b1;
    Start = 1'b1;
    step();
    Reset = 1'b0;
    Start = 1'b0;
    check("rst_start_run", 32'(Running), 32'h0);
    check("rst_start_pc",  32'(ProgCtr), 32'h0);

    // Self-loop: LUT[4]=4, branch at PC=4 stays at 4
    lut_write(5'd4, 10'h004);
    Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    step();
    step();
    step();
    BranchEn = 1'b1;
    Taken    = 1'b1;
    TargIdx  = 5'd4;
    step();
    check("self_loop_pc1", 32'(ProgCtr), 32'h4);
    step();
    idle_ctl();
    check("self_loop_pc2", 32'(ProgCtr), 32'h4);

    // Jump to last address then fall through
    Halt = 1'b1;
    step();
    Halt = 1'b0;
    lut_write(5'd2, 10'h3FF);
    Start = 1'b1;
    step();
    Start = 1'b0;
    Jump    = 1'b1;
    TargIdx = 5'd2;
    step();
    idle_ctl();
    check("last_addr_pc",  32'(ProgCtr), 32'h3FF);
    check("last_addr_run", 32'(Running), 32'h1);
    step();
`ifdef PC_OVERRUN_CHECK_EN
    check("ovr_done",    32'(Done),    32'h1);
    check("ovr_flag",    32'(Overrun), 32'h1);
    check("ovr_pc",      32'(ProgCtr), 32'h3FF);
    check("ovr_run",     32'(Running), 32'h0);
    step();
    check("ovr_hold_flag", 32'(Overrun), 32'h1);
    Start = 1'b1;
    step();
    Start = 1'b0;
    check("ovr_clr_flag", 32'(Overrun), 32'h0);
    check("ovr_clr_pc",   32'(ProgCtr), 32'h0);
`else
    check("wrap_pc",      32'(ProgCtr), 32'h0);
    check("wrap_run",     32'(Running), 32'h1);
    check("wrap_overrun", 32'(Overrun), 32'h0);
    step();
    check("wrap_next_pc", 32'(ProgCtr), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
    $finish;
  end

endmodule
